// File: rtl/input_conditioner.sv
// Switch/button conditioner: flip-flop synchronizer followed by a counter-based
// debouncer that drives a clean level and single-cycle rise/fall pulses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_WAIT} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sy;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;

  // Stage: synchronizer chain, r_sync[0] samples the asynchronous pin
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i};
    end
  end

  assign w_sy = r_sync[SYNC_STAGES-1];

  // Stage: debounce FSM; o only flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      o       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_sy != o) begin
            if (DEBOUNCE_CYCLES == 1) begin
              o    <= w_sy;
              rise <= w_sy;
              fall <= ~w_sy;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (w_sy == o) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            o       <= w_sy;
            rise    <= w_sy;
            fall    <= ~w_sy;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
